// File: rtl/id_emitter.sv
// id_emitter: transmit side of the identifier recogniser.
// On request, emits one identifier as a valid/ready char stream: a run of letters,
// an optional run of digits, then one separator char. A done pulse follows the separator.
module id_emitter #(
  parameter int           LW       = 4,
  parameter logic [7:0]   SEP_CHAR = 8'h20,
  parameter bit           UPPER    = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] let_len,
  input  logic [LW-1:0] dig_len,
  input  logic [4:0]    let_base,
  output logic [7:0]    char,
  output logic          char_valid,
  input  logic          char_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LET  = 2'd1,
    S_DIG  = 2'd2,
    S_SEP  = 2'd3
  } state_t;

  localparam logic [7:0] LETTER_A = UPPER ? 8'h41 : 8'h61;
  localparam logic [7:0] DIGIT_0  = 8'h30;

  state_t        state_q, state_d;
  logic [LW-1:0] let_rem_q, let_rem_d;   // letters still to transfer, incl. current
  logic [LW-1:0] dig_rem_q, dig_rem_d;   // digits still to transfer, incl. current
  logic [4:0]    let_idx_q, let_idx_d;   // letter currently offered, 0..25
  logic [3:0]    dig_val_q, dig_val_d;   // digit currently offered, 0..9
  logic [7:0]    char_q, char_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          xfer;
  logic [4:0]    base_idx;
  logic [4:0]    let_idx_inc;
  logic [3:0]    dig_val_inc;

  assign xfer        = valid_q & char_ready;
  assign base_idx    = (let_base >= 5'd26) ? 5'd0 : let_base;
  assign let_idx_inc = (let_idx_q == 5'd25) ? 5'd0 : let_idx_q + 5'd1;
  assign dig_val_inc = (dig_val_q == 4'd9) ? 4'd0 : dig_val_q + 4'd1;

  // Next-state and next-output computation; outputs are registered so the offered
  // char only changes on an accepted transfer.
  always_comb begin
    state_d   = state_q;
    let_rem_d = let_rem_q;
    dig_rem_d = dig_rem_q;
    let_idx_d = let_idx_q;
    dig_val_d = dig_val_q;
    char_d    = char_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LET;
          let_rem_d = (let_len == '0) ? {{(LW-1){1'b0}}, 1'b1} : let_len;
          dig_rem_d = dig_len;
          let_idx_d = base_idx;
          dig_val_d = 4'd0;
          char_d    = LETTER_A + {3'b000, base_idx};
          valid_d   = 1'b1;
        end
      end
      S_LET: begin
        if (xfer) begin
          if (let_rem_q == {{(LW-1){1'b0}}, 1'b1}) begin
            let_rem_d = '0;
            if (dig_rem_q != '0) begin
              state_d   = S_DIG;
              dig_val_d = 4'd0;
              char_d    = DIGIT_0;
            end else begin
              state_d = S_SEP;
              char_d  = SEP_CHAR;
            end
          end else begin
            let_rem_d = let_rem_q - 1'b1;
            let_idx_d = let_idx_inc;
            char_d    = LETTER_A + {3'b000, let_idx_inc};
          end
        end
      end
      S_DIG: begin
        if (xfer) begin
          if (dig_rem_q == {{(LW-1){1'b0}}, 1'b1}) begin
            dig_rem_d = '0;
            state_d   = S_SEP;
            char_d    = SEP_CHAR;
          end else begin
            dig_rem_d = dig_rem_q - 1'b1;
            dig_val_d = dig_val_inc;
            char_d    = DIGIT_0 + {4'b0000, dig_val_inc};
          end
        end
      end
      S_SEP: begin
        if (xfer) begin
          state_d = S_IDLE;
          char_d  = 8'h00;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        char_d  = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      let_rem_q <= '0;
      dig_rem_q <= '0;
      let_idx_q <= '0;
      dig_val_q <= '0;
      char_q    <= 8'h00;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      let_rem_q <= let_rem_d;
      dig_rem_q <= dig_rem_d;
      let_idx_q <= let_idx_d;
      dig_val_q <= dig_val_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign char       = char_q;
  assign char_valid = valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_id_emitter.sv
// Directed bench for id_emitter: sends packets with known expected char strings,
// checks ordering, stall stability, done timing, reset behaviour and a small
// recogniser model that must flag after the last digit of each packet.
module tb_id_emitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] let_len = '0;
  logic [3:0] dig_len = '0;
  logic [4:0] let_base = '0;
  logic [7:0] char;
  logic       char_valid;
  logic       char_ready = 1'b0;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  int rec_st = 0;  // 0: no identifier, 1: in letters, 2: in digits (recogniser out=1)

  always #5 clk = ~clk;

  id_emitter #(.LW(4), .SEP_CHAR(8'h20), .UPPER(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .let_len    (let_len),
    .dig_len    (dig_len),
    .let_base   (let_base),
    .char       (char),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference recogniser: letters then at least one digit -> out=1.
  task automatic rec_step(input logic [7:0] c);
    if ((c >= 8'h61 && c <= 8'h7a) || (c >= 8'h41 && c <= 8'h5a))
      rec_st = (rec_st == 2) ? 0 : 1;
    else if (c >= 8'h30 && c <= 8'h39)
      rec_st = (rec_st == 0) ? 0 : 2;
    else
      rec_st = 0;
  endtask

  task automatic kick(input logic [3:0] ll, input logic [3:0] dl, input logic [4:0] lb);
    @(negedge clk);
    char_ready = 1'b0;
    start = 1'b1; let_len = ll; dig_len = dl; let_base = lb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready always 1; mode 1: ready 1 plus start pulsed/held mid-packet with
  // other lengths (held until done); mode 2: ready pattern 1,0,0 repeating.
  task automatic recv(input string exp, input int mode, input int rec_exp);
    int n = 0;
    int it = 0;
    bit fin = 0;
    logic [7:0] pc = 8'h00;
    logic pv = 1'b0;
    logic pr = 1'b0;
    rec_st = 0;
    check("first_valid", {31'b0, char_valid}, 32'd1);
    while (!fin && it < 100) begin
      char_ready = (mode == 2) ? (it % 3 == 0) : 1'b1;
      if (mode == 1 && it == 2) begin
        start = 1'b1; let_len = 4'd2; dig_len = 4'd1; let_base = 5'd5;
      end
      if (pv && !pr) begin
        check("stall_valid", {31'b0, char_valid}, 32'd1);
        check("stall_char", {24'b0, char}, {24'b0, pc});
      end
      if (char_valid && char_ready) begin
        check($sformatf("char%0d", n), {24'b0, char}, {24'b0, exp[n]});
        rec_step(char);
        if (n == exp.len() - 2) check("rec_last", rec_st == 2, rec_exp);
        if (n == exp.len() - 1) check("rec_sep", rec_st == 2, 32'd0);
        n++;
      end
      pv = char_valid; pr = char_ready; pc = char;
      if (n == exp.len()) fin = 1'b1;
      else begin
        @(negedge clk);
        it++;
      end
    end
    if (!fin) begin
      check("timeout", 32'd1, 32'd0);
    end else begin
      @(negedge clk);
      check("done_pulse", {31'b0, done}, 32'd1);
      check("done_valid", {31'b0, char_valid}, 32'd0);
      check("done_busy", {31'b0, busy}, 32'd0);
      // With ready held, done shows L cycles after the start edge was sampled.
      if (mode != 2) check("done_latency", it + 1, exp.len());
      @(negedge clk);
      if (mode == 1) start = 1'b0;
      check("done_once", {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    #1;
    check("rst_char", {24'b0, char}, 32'd0);
    check("rst_valid", {31'b0, char_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ready while idle must not start anything
    char_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", {31'b0, char_valid}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // 1: basic packet
    kick(4'd3, 4'd2, 5'd0);
    check("busy_pkt", {31'b0, busy}, 32'd1);
    recv("abc01 ", 0, 1);
    $display("pkt1 let=3 dig=2 base=0 done");

    // 2: same packet with stalls
    kick(4'd3, 4'd2, 5'd0);
    recv("abc01 ", 2, 1);
    $display("pkt2 stalled done");

    // 3: letter wrap and digit wrap
    kick(4'd4, 4'd12, 5'd24);
    recv("yzab012345678901 ", 0, 1);
    $display("pkt3 let=4 dig=12 base=24 done");

    // 4: zero lengths, out-of-range base
    kick(4'd0, 4'd0, 5'd30);
    recv("a ", 0, 0);
    $display("pkt4 let=0 dig=0 base=30 done");

    // 5: start mid-packet ignored, held through done -> next packet (2,1,5)
    kick(4'd3, 4'd2, 5'd0);
    recv("abc01 ", 1, 1);
    recv("fg0 ", 0, 1);
    $display("pkt5 mid-start ignored, chained packet done");

    // 6: async reset during digit run
    kick(4'd3, 4'd2, 5'd0);
    char_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_digit", {24'b0, char}, 32'h30);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, char_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_char", {24'b0, char}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("arst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("post_rst_done", {31'b0, done}, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    kick(4'd3, 4'd2, 5'd0);
    recv("abc01 ", 0, 1);
    $display("pkt6 reset mid-packet then full packet done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
